// File: rtl/usb_stream_in_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_stream_in_feeder_if
// Purpose  : Producer-side and writer-side signals of the stream-in feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_stream_in_feeder_if #(
    parameter int ADDR_W = 4
);
    logic [31:0]     in_data;
    logic            in_valid;
    logic            in_ready;
    logic            slwr_n;
    logic [31:0]     data_out;
    logic [ADDR_W:0] level;
    logic            stream_req;
    logic            flush_active;
    logic            underrun;
    logic            overrun;

    modport master (
        output in_data, in_valid, slwr_n,
        input  in_ready, data_out, level, stream_req, flush_active, underrun, overrun
    );

    modport slave (
        input  in_data, in_valid, slwr_n,
        output in_ready, data_out, level, stream_req, flush_active, underrun, overrun
    );
endinterface
`default_nettype wire

// File: rtl/usb_stream_in_feeder.sv
`default_nettype none
// ============================================================================
// Module   : usb_stream_in_feeder
// Purpose  : FWFT word FIFO feeding the FX3 stream-in writer; requests stream
//            mode once a full burst is buffered. Define USB_FEED_FLUSH_EN to
//            also flush partial bursts after FLUSH_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module usb_stream_in_feeder #(
    parameter int ADDR_W       = 4,
    parameter int BURST_WORDS  = 8,
    parameter int FLUSH_CYCLES = 256
) (
    input logic                   clk,
    input logic                   rst,
    usb_stream_in_feeder_if.slave bus
);

    localparam int              c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_LVL_FULL  = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_LVL_BURST = (ADDR_W + 1)'(BURST_WORDS);
    localparam logic [ADDR_W:0] c_CNT_LAST  = (ADDR_W + 1)'(BURST_WORDS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BURST = 2'd1;
`ifdef USB_FEED_FLUSH_EN
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
`endif

    generate
        if (BURST_WORDS < 1 || BURST_WORDS > c_DEPTH || FLUSH_CYCLES < 1) begin : g_bad_params
            $error("usb_stream_in_feeder: illegal parameter combination");
        end
    endgenerate

    logic [31:0]       r_mem [0:c_DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_underrun;
    logic              r_overrun;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W:0]   r_burst_cnt;
    logic [ADDR_W:0]   w_burst_cnt_nxt;

    logic w_full;
    logic w_level_zero;
    logic w_level_ge_burst;
    logic w_push;
    logic w_pop;

    assign w_full           = (r_level == c_LVL_FULL);
    assign w_level_zero     = (r_level == '0);
    assign w_level_ge_burst = (r_level >= c_LVL_BURST);
    assign w_push           = bus.in_valid & ~w_full;
    assign w_pop            = ~bus.slwr_n & ~w_level_zero;

    // Storage is never reset; pointers and level alone define the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (bus.in_valid && w_full) begin
                r_overrun <= 1'b1;
            end
            if (!bus.slwr_n && w_level_zero) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef USB_FEED_FLUSH_EN
    localparam int                 c_TMR_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(FLUSH_CYCLES - 1);

    logic [c_TMR_W-1:0] r_idle_tmr;
    logic               w_idle_count;
    logic               w_flush_due;

    // Only a quiet, partially filled FIFO ages toward a flush.
    assign w_idle_count = (r_state == c_ST_IDLE) && !w_level_zero && !w_level_ge_burst && !w_push;
    assign w_flush_due  = w_idle_count && (r_idle_tmr == c_TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_idle_count || w_flush_due) begin
            r_idle_tmr <= '0;
        end else begin
            r_idle_tmr <= r_idle_tmr + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_level_ge_burst) begin
                    w_state_nxt     = c_ST_BURST;
                    w_burst_cnt_nxt = '0;
                end
`ifdef USB_FEED_FLUSH_EN
                else if (w_flush_due) begin
                    w_state_nxt = c_ST_FLUSH;
                end
`endif
            end
            c_ST_BURST: begin
                if (w_pop) begin
                    if (r_burst_cnt == c_CNT_LAST) begin
                        w_state_nxt     = c_ST_IDLE;
                        w_burst_cnt_nxt = '0;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end
                end
            end
`ifdef USB_FEED_FLUSH_EN
            c_ST_FLUSH: begin
                if (w_level_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt     = c_ST_IDLE;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.in_ready = ~w_full;
    assign bus.data_out = r_mem[r_rd_ptr];
    assign bus.level    = r_level;
    assign bus.underrun = r_underrun;
    assign bus.overrun  = r_overrun;
`ifdef USB_FEED_FLUSH_EN
    assign bus.stream_req   = (r_state == c_ST_BURST) || (r_state == c_ST_FLUSH);
    assign bus.flush_active = (r_state == c_ST_FLUSH);
`else
    assign bus.stream_req   = (r_state == c_ST_BURST);
    assign bus.flush_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_stream_in_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_stream_in_feeder
// Purpose  : Directed bench for usb_stream_in_feeder with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_stream_in_feeder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BW     = 8;
    localparam int FC     = 16;
`ifdef USB_FEED_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_stream_in_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    usb_stream_in_feeder #(
        .ADDR_W       (ADDR_W),
        .BURST_WORDS  (BW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus burst/flush bookkeeping.
    logic [31:0] mq[$];
    bit m_req, m_flush, m_under, m_over, model_ok;
    int m_served, m_idle_run, m_lvl;
    bit m_push, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_req = 0; m_flush = 0; m_under = 0; m_over = 0;
            m_served = 0; m_idle_run = 0;
            model_ok = 1;
        end else if (model_ok) begin
            m_lvl  = mq.size();
            m_push = bus.in_valid && (m_lvl < DEPTH);
            m_pop  = !bus.slwr_n && (m_lvl > 0);
            if (bus.in_valid && m_lvl == DEPTH) m_over = 1;
            if (!bus.slwr_n && m_lvl == 0) m_under = 1;
            if (m_req) begin
                m_idle_run = 0;
                if (m_pop) begin
                    m_served++;
                    if (m_served == BW) m_req = 0;
                end
            end else if (m_flush) begin
                if (m_lvl == 0) m_flush = 0;
            end else if (m_lvl >= BW) begin
                m_req = 1; m_served = 0; m_idle_run = 0;
            end else if (FLUSH_EN && m_lvl > 0 && !m_push) begin
                m_idle_run++;
                if (m_idle_run == FC) begin
                    m_flush = 1; m_idle_run = 0;
                end
            end else begin
                m_idle_run = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(bus.in_data);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model.level",        32'(bus.level),   32'(mq.size()));
            check("model.in_ready",     32'(bus.in_ready), 32'(mq.size() < DEPTH));
            check("model.stream_req",   32'(bus.stream_req), 32'(m_req || m_flush));
            check("model.flush_active", 32'(bus.flush_active), 32'(m_flush));
            check("model.underrun",     32'(bus.underrun), 32'(m_under));
            check("model.overrun",      32'(bus.overrun),  32'(m_over));
            if (mq.size() > 0) check("model.data_out", bus.data_out, mq[0]);
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit sn);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.slwr_n   = sn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("rst.level",      32'(bus.level), 0);
        check("rst.in_ready",   32'(bus.in_ready), 1);
        check("rst.stream_req", 32'(bus.stream_req), 0);
        check("rst.flags",      32'({bus.underrun, bus.overrun, bus.flush_active}), 0);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.slwr_n   = 1'b1;

        // Burst of 8, drained in order
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 32'(i), 1);
        check("t1.level8", 32'(bus.level), 8);
        cyc(0, 0, 1);
        check("t1.req_up", 32'(bus.stream_req), 1);
        for (int i = 1; i <= 8; i++) begin
            check("t1.data_out", bus.data_out, 32'(i));
            cyc(0, 0, 0);
        end
        check("t1.level0", 32'(bus.level), 0);
        check("t1.req_down", 32'(bus.stream_req), 0);
        cyc(0, 0, 1);

        // Full FIFO, overrun, one pop frees a slot
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 32'h100 + 32'(i), 1);
        check("t2.level16", 32'(bus.level), 16);
        check("t2.not_ready", 32'(bus.in_ready), 0);
        check("t2.no_overrun", 32'(bus.overrun), 0);
        cyc(1, 32'hDEAD, 1);
        check("t2.overrun", 32'(bus.overrun), 1);
        check("t2.head", bus.data_out, 32'h100);
        cyc(0, 0, 0);
        check("t2.ready", 32'(bus.in_ready), 1);
        check("t2.level15", 32'(bus.level), 15);
        check("t2.head2", bus.data_out, 32'h101);

        // Underrun, then pop-at-empty with a concurrent push
        do_reset();
        cyc(0, 0, 0);
        check("t3.underrun", 32'(bus.underrun), 1);
        check("t3.level0", 32'(bus.level), 0);
        cyc(1, 32'hA5, 0);
        check("t3.level1", 32'(bus.level), 1);
        check("t3.data", bus.data_out, 32'hA5);
        cyc(0, 0, 1);

        // Steady push+pop across the pointer wrap
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 32'h200 + 32'(i), 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 32'h300 + 32'(i), 0);
        check("t4.level8", 32'(bus.level), 8);
        check("t4.head", bus.data_out, 32'h30C);
        cyc(0, 0, 1);

        // Partial burst: flush when enabled, otherwise waits forever
        do_reset();
        for (int i = 1; i <= 3; i++) cyc(1, 32'h400 + 32'(i), 1);
`ifdef USB_FEED_FLUSH_EN
        repeat (FC - 1) cyc(0, 0, 1);
        check("t5.no_req_yet", 32'(bus.stream_req), 0);
        cyc(0, 0, 1);
        check("t5.req", 32'(bus.stream_req), 1);
        check("t5.flush", 32'(bus.flush_active), 1);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("t5.req_end", 32'(bus.stream_req), 0);
        check("t5.flush_end", 32'(bus.flush_active), 0);
`else
        repeat (40) cyc(0, 0, 1);
        check("t5.no_req", 32'(bus.stream_req), 0);
        check("t5.no_flush", 32'(bus.flush_active), 0);
        check("t5.level3", 32'(bus.level), 3);
`endif

        // Reset in the middle of a burst
        do_reset();
        cyc(0, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(1, 32'h500 + 32'(i), 1);
        cyc(0, 0, 1);
        repeat (4) cyc(0, 0, 0);
        check("t6.level4", 32'(bus.level), 4);
        check("t6.req", 32'(bus.stream_req), 1);
        check("t6.under_set", 32'(bus.underrun), 1);
        rst = 1'b1;
        cyc(0, 0, 1);
        check("t6.level0", 32'(bus.level), 0);
        check("t6.req0", 32'(bus.stream_req), 0);
        check("t6.flags0", 32'({bus.underrun, bus.overrun}), 0);
        check("t6.ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        cyc(0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
